// File: rtl/i2c_packet_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_packet_loader_pkg
// Purpose : Shared FSM encoding, default parameters and helpers for the
//           I2C LUT packet loader.
// Rev     : 1.0  initial release
// ============================================================================
package i2c_packet_loader_pkg;

  // Default 7-bit write address and LUT packet size (3 x 256 entries, R/G/B)
  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h3C;
  localparam int         DEF_PKT_LEN    = 768;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } state_t;

  // Both acknowledge states share one SCL-fall driven pull-down sequence
  function automatic logic is_ack_state(input state_t s);
    return (s == ADDR_ACK) || (s == DATA_ACK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_packet_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : i2c_packet_loader_if
// Purpose : Bundles the raw I2C pad signals and the byte-stream outputs that
//           feed the colour-correction LUT loader.
// Rev     : 1.0  initial release
// ============================================================================
interface i2c_packet_loader_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       SOP;
  logic       EOP;
  logic       VLD;
  logic [7:0] packet_data;
  logic       pkt_err;

  // The loader is the I2C slave and the producer of the byte stream
  modport slave (
    input  scl_i, sda_i,
    output sda_oe, SOP, EOP, VLD, packet_data, pkt_err
  );

  // Bus master / stream consumer side
  modport master (
    output scl_i, sda_i,
    input  sda_oe, SOP, EOP, VLD, packet_data, pkt_err
  );
endinterface
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : i2c_sync_edge
// Purpose : Two-flop synchroniser for an asynchronous pad input plus a third
//           flop for rise/fall detection. Flops reset to 1 (idle I2C line).
// Rev     : 1.0  initial release
// ============================================================================
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // sr[0]/sr[1] form the synchroniser, sr[2] holds the previous synced value
  logic [2:0] sr;

  // Shift the pad value through the synchroniser and history flop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr <= 3'b111;
    else      sr <= {sr[1:0], din};
  end

  assign level = sr[1];
  assign rise  = sr[1] & ~sr[2];
  assign fall  = ~sr[1] & sr[2];

endmodule
`default_nettype wire

// File: rtl/i2c_packet_loader.sv
`default_nettype none
// ============================================================================
// Module  : i2c_packet_loader
// Purpose : I2C write-only slave that streams received bytes as a fixed
//           length LUT packet with SOP/EOP/VLD framing and abort detection.
// Rev     : 1.0  initial release
// ============================================================================
module i2c_packet_loader
  import i2c_packet_loader_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int         PKT_LEN    = DEF_PKT_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_packet_loader_if.slave     bus
);

  localparam int                CNT_W = $clog2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0]  LEN   = CNT_W'(PKT_LEN);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PKT_LEN - 1);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk(clk), .rst(rst), .din(bus.scl_i),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk(clk), .rst(rst), .din(bus.sda_i),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  state_t           state, state_nxt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] byte_cnt;
  logic             sda_oe_q;
  logic             sop_q, eop_q, vld_q, err_q;
  logic [7:0]       data_q;

  logic       start_det, stop_det, shifting, byte_end, addr_ok, emit;
  logic [7:0] shift_nxt;

  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;
  assign shifting  = scl_rise && ((state == ADDR) || (state == DATA));
  assign byte_end  = shifting && (bit_cnt == 3'd7);
  assign shift_nxt = {shreg[6:0], sda};
  assign addr_ok   = (shift_nxt[7:1] == SLAVE_ADDR) && !shift_nxt[0];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; START/STOP take priority over everything in any state
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    if (start_det) begin
      state_nxt = ADDR;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        ADDR: begin
          if (byte_end) state_nxt = addr_ok ? ADDR_ACK : IGNORE;
        end
        ADDR_ACK, DATA_ACK: begin
          // Second SCL fall of the ACK slot releases SDA and resumes data
          if (scl_fall && sda_oe_q) state_nxt = DATA;
        end
        DATA: begin
          if (byte_end) begin
            if (byte_cnt < LEN) begin
              state_nxt = DATA_ACK;
              emit      = 1'b1;
            end else begin
              state_nxt = IGNORE;
            end
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Bit shifter, ACK pull-down, byte framing and packet-abort tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      byte_cnt <= '0;
      sda_oe_q <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      vld_q <= 1'b0;
      err_q <= 1'b0;

      if (start_det || stop_det) begin
        bit_cnt <= 3'd0;
      end else if (shifting) begin
        shreg   <= shift_nxt;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (start_det || stop_det) begin
        sda_oe_q <= 1'b0;
      end else if (is_ack_state(state) && scl_fall) begin
        sda_oe_q <= ~sda_oe_q;
      end

      if (emit) begin
        vld_q    <= 1'b1;
        data_q   <= shift_nxt;
        sop_q    <= (byte_cnt == '0);
        eop_q    <= (byte_cnt == LAST);
        byte_cnt <= byte_cnt + 1'b1;
      end

      // Any bus boundary ends the current packet; a partial one is reported
      if (start_det || stop_det) begin
        byte_cnt <= '0;
        if ((byte_cnt != '0) && (byte_cnt != LEN)) err_q <= 1'b1;
      end
    end
  end

  assign bus.sda_oe      = sda_oe_q;
  assign bus.SOP         = sop_q;
  assign bus.EOP         = eop_q;
  assign bus.VLD         = vld_q;
  assign bus.packet_data = data_q;
  assign bus.pkt_err     = err_q;

endmodule
`default_nettype wire
